text_readback_port: RTL and testbench
=====================================

// Module: text_readback_port
// PURPOSE
// - Port-mapped readback of the character display for the kcpsm3 CPU: keeps a shadow copy of every
//   character the CPU writes to the display text memory and returns it on in_port during INPUT.
// - Sits on the CPU port bus beside the dsp write path; owns the row register and adds a streaming cursor.
// PARAMETERS
// ROW_BITS   5  row index width (2**ROW_BITS rows)
// COL_BITS   7  column width; must equal 7 (column = port_id[6:0])
// DATA_BITS  8  character width
// PORTS
// clk           in   1   system clock, all state on rising edge
// reset         in   1   asynchronous, active-high reset
// port_id       in   8   CPU port address
// write_strobe  in   1   CPU OUTPUT strobe, one cycle
// read_strobe   in   1   CPU INPUT strobe, one cycle; in_port sampled by CPU on the edge ending it
// out_port      in   8   CPU write data
// in_port       out  8   registered read data to CPU
// row           out  5   current row register (drives upper display address bits)
// BEHAVIOUR
// - Port map, writes (write_strobe=1): 0x00-0x7F -> shadow[row][port_id[6:0]] <= out_port;
//   0x80 -> row <= out_port[4:0]; 0x81 -> col <= out_port[6:0];
//   0x82 -> shadow[row][col] <= out_port, then cursor advance; 0x83-0xFF ignored.
// - Port map, reads: 0x00-0x7F -> shadow[row][port_id[6:0]]; 0x80 -> {3'b0,row}; 0x81 -> {1'b0,col};
//   0x82 -> shadow[row][col], cursor advances on the edge ending read_strobe; 0x83-0xFF -> 8'h00.
// - Shadow: 4096x8 synchronous single-port-write RAM, not reset (contents undefined until written).
// - Read pipeline: port_id is stable for two cycles per CPU port access; RAM read address and in_port mux
//   are registered every cycle from current port_id regardless of strobes, so in_port is valid in the
//   read_strobe cycle (latency 1 from port_id). in_port updates every cycle; only strobe cycle matters.
// - RAM read address for 0x82 is {row,col}; else {row,port_id[6:0]}.
// - Read-after-write: a write on edge N is visible to a read addressed in the cycle after edge N.
// - Cursor advance: col <= col+1; if col==127 then col <= 0 and row <= row+1 (row wraps 31 -> 0).
//   Advance happens once per strobe, never on non-strobe cycles.
// - Simultaneous write_strobe and read_strobe (not produced by kcpsm3): write wins, read side effects
//   (cursor advance) suppressed.
// - A write to 0x80/0x81 takes effect for any access whose port_id appears after the write edge.
// - Reset (async, any time incl. mid-access): row=0, col=0, in_port=8'h00; RAM untouched; an in-flight
//   INPUT returns 8'h00 and causes no advance.
// TESTING
// 1 Reset: assert reset mid-cycle -> in_port=0x00, row=0; read 0x80 -> 0x00; read 0x81 -> 0x00.
// 2 OUT 0x80<=0x03, OUT 0x05<=0x41, OUT 0x80<=0x04, OUT 0x05<=0x42; set row 3, IN 0x05 -> 0x41;
//   row 4, IN 0x05 -> 0x42; row output tracks 3/4.
// 3 Streaming: row=2, OUT 0x81<=0x7E, OUT 0x82 x3 with 0x10,0x11,0x12 -> row=3, col=1;
//   row=2, col=0x7E, IN 0x82 x3 -> 0x10,0x11,0x12 then read 0x80 -> 0x03, 0x81 -> 0x01.
// 4 Row wrap: row=31, col=127, IN 0x82 -> row=0, col=0.
// 5 Back-to-back OUT 0x10<=0x55 then IN 0x10 on next access -> 0x55; IN 0x90 -> 0x00, no state change.
// 6 Strobe hygiene: hold port_id=0x82 for 10 cycles without strobes -> col unchanged; both strobes high
//   together at 0x82 -> char written, col advances exactly once.

Source files
------------

// File: rtl/text_readback_port.sv
// rtl/text_readback_port.sv - shadow text memory and streaming cursor readback for the kcpsm3 port bus
//
// Purpose: keeps a copy of every character the CPU writes to display text memory
// and returns it on in_port during INPUT. Owns the row register and a column
// cursor that auto-advances on port 0x82 accesses.
//
// Ports:
//   clk          - system clock, all state on rising edge
//   reset        - asynchronous active-high reset
//   port_id      - CPU port address
//   write_strobe - CPU OUTPUT strobe (one cycle)
//   read_strobe  - CPU INPUT strobe (one cycle)
//   out_port     - CPU write data
//   in_port      - registered read data to CPU
//   row          - current row register (upper display address bits)

module text_readback_port #(
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           port_id,
  input  logic                 write_strobe,
  input  logic                 read_strobe,
  input  logic [DATA_BITS-1:0] out_port,
  output logic [DATA_BITS-1:0] in_port,
  output logic [ROW_BITS-1:0]  row
);

  localparam int ADDR_BITS = ROW_BITS + COL_BITS;
  localparam int DEPTH     = 1 << ADDR_BITS;

  localparam logic [7:0] P_ROW    = 8'h80;
  localparam logic [7:0] P_COL    = 8'h81;
  localparam logic [7:0] P_STREAM = 8'h82;

  logic [DATA_BITS-1:0] r_shadow [DEPTH];
  logic [ROW_BITS-1:0]  r_row;
  logic [COL_BITS-1:0]  r_col;
  logic [DATA_BITS-1:0] r_in_port;

  logic                 w_is_stream;
  logic                 w_is_direct;
  logic [ADDR_BITS-1:0] w_addr;
  logic                 w_advance;

  assign w_is_stream = (port_id == P_STREAM);
  assign w_is_direct = ~port_id[7];

  // One address serves both the write port and the read port: the cursor for
  // 0x82, otherwise the current row with the column taken from port_id.
  assign w_addr = w_is_stream ? {r_row, r_col} : {r_row, port_id[COL_BITS-1:0]};

  // Either strobe on 0x82 advances once; with both high the write happens and
  // the read side effect collapses into the same single advance.
  assign w_advance = w_is_stream & (write_strobe | read_strobe);

  // Shadow RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (write_strobe && (w_is_direct || w_is_stream)) begin
      r_shadow[w_addr] <= out_port;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (write_strobe && port_id == P_ROW) begin
      r_row <= out_port[ROW_BITS-1:0];
    end else if (write_strobe && port_id == P_COL) begin
      r_col <= out_port[COL_BITS-1:0];
    end else if (w_advance) begin
      // Treating {row,col} as one counter gives column wrap into the next row
      // and row wrap 31 -> 0 for free.
      {r_row, r_col} <= {r_row, r_col} + ADDR_BITS'(1);
    end
  end

  // Read data is refreshed every cycle from the current port_id so it is
  // already valid during the strobe cycle of a two-cycle CPU access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_port <= '0;
    end else if (w_is_direct || w_is_stream) begin
      r_in_port <= r_shadow[w_addr];
    end else if (port_id == P_ROW) begin
      r_in_port <= DATA_BITS'(r_row);
    end else if (port_id == P_COL) begin
      r_in_port <= DATA_BITS'(r_col);
    end else begin
      r_in_port <= '0;
    end
  end

  assign in_port = r_in_port;
  assign row     = r_row;

endmodule

// File: tb/tb_text_readback_port.sv
// tb/tb_text_readback_port.sv - self-checking bench for text_readback_port

module tb_text_readback_port;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] port_id = 8'h00;
  logic       write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic [7:0] out_port = 8'h00;
  logic [7:0] in_port;
  logic [4:0] row;

  int total = 0;
  int bad = 0;

  // Reference model: a flat character array plus one linear cursor index
  // (cursor = row*128 + col).
  logic [7:0] m_mem [4096];
  bit         m_ok  [4096];
  int         m_cur = 0;

  text_readback_port dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .out_port     (out_port),
    .in_port      (in_port),
    .row          (row)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic [7:0] pid, input logic [7:0] data);
    int a;
    if (pid < 8'h80) begin
      a = (m_cur / 128) * 128 + int'(pid);
      m_mem[a] = data;
      m_ok[a]  = 1'b1;
    end else if (pid == 8'h80) begin
      m_cur = int'(data % 32) * 128 + (m_cur % 128);
    end else if (pid == 8'h81) begin
      m_cur = (m_cur / 128) * 128 + int'(data % 128);
    end else if (pid == 8'h82) begin
      m_mem[m_cur] = data;
      m_ok[m_cur]  = 1'b1;
      m_cur = (m_cur + 1) % 4096;
    end
  endtask

  task automatic model_read(input logic [7:0] pid, output logic [7:0] exp, output bit known);
    int a;
    known = 1'b1;
    exp   = 8'h00;
    if (pid < 8'h80) begin
      a = (m_cur / 128) * 128 + int'(pid);
      exp = m_mem[a];
      known = m_ok[a];
    end else if (pid == 8'h80) begin
      exp = 8'(m_cur / 128);
    end else if (pid == 8'h81) begin
      exp = 8'(m_cur % 128);
    end else if (pid == 8'h82) begin
      exp = m_mem[m_cur];
      known = m_ok[m_cur];
      m_cur = (m_cur + 1) % 4096;
    end
  endtask

  // One CPU port access: port_id for a cycle, then the strobe cycle, then idle.
  task automatic access(input string tag, input logic [7:0] pid, input logic [7:0] data,
                        input bit wr, input bit rd);
    logic [7:0] exp;
    bit known;
    @(negedge clk);
    port_id = pid;
    write_strobe = 1'b0;
    read_strobe = 1'b0;
    out_port = data;
    @(negedge clk);
    write_strobe = wr;
    read_strobe = rd;
    if (wr) begin
      model_write(pid, data);
    end else if (rd) begin
      model_read(pid, exp, known);
      if (known) check(tag, in_port, exp);
    end
    @(negedge clk);
    write_strobe = 1'b0;
    read_strobe = 1'b0;
  endtask

  task automatic out_op(input logic [7:0] pid, input logic [7:0] data);
    access("out", pid, data, 1'b1, 1'b0);
  endtask

  task automatic in_op(input string tag, input logic [7:0] pid);
    access(tag, pid, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic check_row(input string tag);
    check(tag, {3'b000, row}, 8'(m_cur / 128));
  endtask

  initial begin
    logic [7:0] pid;
    logic [7:0] data;
    int kind;
    bit wr;
    bit rd;

    for (int i = 0; i < 4096; i++) m_ok[i] = 1'b0;

    // 1: reset, including an asynchronous assertion mid-cycle
    repeat (3) @(negedge clk);
    reset = 1'b0;
    out_op(8'h80, 8'h07);
    out_op(8'h81, 8'h09);
    @(negedge clk);
    port_id = 8'h80;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_in_port", in_port, 8'h00);
    check("rst_row", {3'b000, row}, 8'h00);
    m_cur = 0;
    @(negedge clk);
    reset = 1'b0;
    in_op("rst_rd80", 8'h80);
    in_op("rst_rd81", 8'h81);

    // 2: direct character writes in two rows
    out_op(8'h80, 8'h03);
    check_row("row3");
    out_op(8'h05, 8'h41);
    out_op(8'h80, 8'h04);
    check_row("row4");
    out_op(8'h05, 8'h42);
    out_op(8'h80, 8'h03);
    in_op("rd_r3c5", 8'h05);
    out_op(8'h80, 8'h04);
    in_op("rd_r4c5", 8'h05);
    check_row("row4b");

    // 3: streaming across a row boundary
    out_op(8'h80, 8'h02);
    out_op(8'h81, 8'h7E);
    out_op(8'h82, 8'h10);
    out_op(8'h82, 8'h11);
    out_op(8'h82, 8'h12);
    check_row("stream_row");
    in_op("stream_col", 8'h81);
    out_op(8'h80, 8'h02);
    out_op(8'h81, 8'h7E);
    in_op("stream_rd0", 8'h82);
    in_op("stream_rd1", 8'h82);
    in_op("stream_rd2", 8'h82);
    in_op("stream_rd80", 8'h80);
    in_op("stream_rd81", 8'h81);

    // 4: cursor wrap from last row/column back to zero
    out_op(8'h80, 8'h1F);
    out_op(8'h81, 8'h7F);
    in_op("wrap_rd", 8'h82);
    check_row("wrap_row");
    in_op("wrap_col", 8'h81);

    // 5: back-to-back write then read, and an unmapped read
    out_op(8'h10, 8'h55);
    in_op("raw_rd", 8'h10);
    in_op("unmapped", 8'h90);
    in_op("unmapped_row", 8'h80);
    in_op("unmapped_col", 8'h81);

    // 6: strobe hygiene
    out_op(8'h81, 8'h20);
    @(negedge clk);
    port_id = 8'h82;
    repeat (10) @(negedge clk);
    in_op("hold_col", 8'h81);
    access("both", 8'h82, 8'h66, 1'b1, 1'b1);
    in_op("both_col", 8'h81);
    out_op(8'h81, 8'h20);
    in_op("both_char", 8'h82);

    // Randomised mix against the model; rows kept small so reads hit written data.
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      data = 8'($urandom);
      case (kind)
        0, 1, 2, 3: pid = 8'($urandom_range(0, 127));
        4:          begin pid = 8'h80; data = 8'($urandom_range(0, 3)); end
        5:          pid = 8'h81;
        6, 7, 8:    pid = 8'h82;
        default:    pid = 8'($urandom_range(131, 255));
      endcase
      wr = ($urandom_range(0, 1) == 1);
      rd = !wr || ($urandom_range(0, 15) == 0);
      access("rand", pid, data, wr, rd);
      if (n % 16 == 0) check_row("rand_row");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
